pc_fetch_ctrl: RTL

//  Program-counter and fetch-control stage directly upstream of the pipelined CPU core.

---
 rtl/pc_fetch_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// Program counter and run-control sequencer feeding the pipelined core's fetch stage.
// Optional performance counters are built when PCFETCH_PERF_EN is defined.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VEC    = 32'h0000_0000,
  parameter logic [31:0] END_ADDR     = 32'h0000_00FC,
  parameter int unsigned BOOT_CYCLES  = 2,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             PCWrite,
  input  logic [31:0]      Addr_Out,
  output logic [31:0]      Addr_In,
  output logic             fetch_valid,
  output logic             busy,
  output logic             halted,
  output logic             end_hit,
  output logic             misalign,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned SEQ_W = 4;
  localparam logic [SEQ_W-1:0] BOOT_LAST  = SEQ_W'(BOOT_CYCLES - 1);
  localparam logic [SEQ_W-1:0] DRAIN_LAST = SEQ_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BOOT  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t           state;
  logic [SEQ_W-1:0] seq_cnt;

  // Run-control FSM; status outputs are registered alongside the state they decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      seq_cnt     <= '0;
      Addr_In     <= RESET_VEC;
      fetch_valid <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      end_hit     <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            state   <= S_BOOT;
            seq_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        S_BOOT: begin
          if (seq_cnt == BOOT_LAST) begin
            state       <= S_RUN;
            fetch_valid <= 1'b1;
          end else begin
            seq_cnt <= seq_cnt + SEQ_W'(1);
          end
        end
        S_RUN: begin
          // A stalled cycle never triggers; misalignment wins over the end address.
          if (PCWrite) begin
            if (Addr_Out[1:0] != 2'b00) begin
              state       <= S_HALT;
              misalign    <= 1'b1;
              fetch_valid <= 1'b0;
              busy        <= 1'b0;
              halted      <= 1'b1;
            end else begin
              Addr_In <= Addr_Out;
              if (Addr_In == END_ADDR) begin
                state       <= S_DRAIN;
                seq_cnt     <= '0;
                end_hit     <= 1'b1;
                fetch_valid <= 1'b0;
              end
            end
          end
        end
        S_DRAIN: begin
          if (seq_cnt == DRAIN_LAST) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            seq_cnt <= seq_cnt + SEQ_W'(1);
          end
        end
        S_HALT: begin
        end
        default: begin
          state       <= S_IDLE;
          fetch_valid <= 1'b0;
          busy        <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

`ifdef PCFETCH_PERF_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] stall_q;

  // Saturating counters; they only move in RUN/DRAIN so HALT freezes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= '0;
      stall_q <= '0;
    end else begin
      if ((state == S_RUN || state == S_DRAIN) && cycle_q != '1)
        cycle_q <= cycle_q + CNT_W'(1);
      if (state == S_RUN && !PCWrite && stall_q != '1)
        stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cycle_q;
  assign stall_cnt = stall_q;
`else
  assign cycle_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule
